// File: rtl/oppm_pkg.sv
// Items shared by the OPPM transmit and receive ends of the optical link.
package oppm_pkg;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, HOLD} rx_state_t;

  localparam int unsigned DEF_L = 4;
  localparam int unsigned DEF_N = 2;

  // Symbol window length in clk cycles.
  function automatic int unsigned p_cycles(input int unsigned l, input int unsigned n);
    return l * (32'd1 << n);
  endfunction

endpackage

// File: rtl/oppm_slot_timer.sv
// Slot and symbol counters spanning one 2^N-slot OPPM window of L clk per slot.
module oppm_slot_timer #(
  parameter int unsigned L = 4,
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  output logic [N-1:0] symbol_id,
  output logic         symbol_last,
  output logic         window_end
);

  localparam int unsigned SW = (L > 1) ? $clog2(L) : 1;

  logic [SW-1:0] slot_ct;
  logic          slot_last;

  assign slot_last   = (slot_ct == SW'(L - 1));
  assign symbol_last = (symbol_id == {N{1'b1}});
  assign window_end  = symbol_last & slot_last;

  // symbol_id wraps naturally at 2^N, so the next window starts at zero.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      slot_ct   <= '0;
      symbol_id <= '0;
    end else if (slot_last) begin
      slot_ct   <= '0;
      symbol_id <= symbol_id + N'(1);
    end else begin
      slot_ct <= slot_ct + SW'(1);
    end
  end

endmodule

// File: rtl/oppm_receiver.sv
// OPPM demodulator: sync detect, per-window first-pulse decode, word packing
// with a valid/ack handoff.
module oppm_receiver
  import oppm_pkg::*;
#(
  parameter int unsigned L        = DEF_L,
  parameter int unsigned N        = DEF_N,
  parameter int unsigned OUTWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pulse_in,
  output logic [OUTWIDTH-1:0] data_out,
  output logic                data_valid,
  input  logic                data_ack,
  output logic                frame_err,
  output logic                busy
);

  localparam int unsigned K  = OUTWIDTH / N;
  localparam int unsigned KW = $clog2(K + 1);

  rx_state_t           state;
  logic                sync1, sync2, sync3, rise;
  logic                got;
  logic [N-1:0]        sym_q;
  logic [KW-1:0]       win_ct;
  logic [OUTWIDTH-1:0] shreg;

  logic                timer_clear;
  logic [N-1:0]        symbol_id;
  logic                symbol_last;
  logic                window_end;
  logic                window_close;
  logic                have_sym;
  logic [N-1:0]        sym_now;
  logic [OUTWIDTH-1:0] shifted;

  // Timer idles at zero so a sync edge starts the preamble window at count 0.
  assign timer_clear  = ((state == IDLE) && !rise) || (state == HOLD);
  assign window_close = window_end & symbol_last;

  oppm_slot_timer #(.L(L), .N(N)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (timer_clear),
    .symbol_id   (symbol_id),
    .symbol_last (symbol_last),
    .window_end  (window_end)
  );

  // An edge on the closing cycle still counts for the closing window.
  always_comb begin
    have_sym = got | rise;
    sym_now  = got ? sym_q : symbol_id;
    shifted  = (shreg << N) | OUTWIDTH'(sym_now);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      rise       <= 1'b0;
      got        <= 1'b0;
      sym_q      <= '0;
      win_ct     <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync1     <= pulse_in;
      sync2     <= sync1;
      sync3     <= sync2;
      rise      <= sync2 & ~sync3;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= PREAMBLE;
            busy  <= 1'b1;
          end
        end
        PREAMBLE: begin
          if (window_close) begin
            state  <= DATA;
            win_ct <= '0;
            got    <= 1'b0;
            shreg  <= '0;
          end
        end
        DATA: begin
          if (window_close) begin
            got <= 1'b0;
            if (!have_sym) begin
              frame_err <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end else begin
              shreg <= shifted;
              if (win_ct == KW'(K - 1)) begin
                data_out   <= shifted;
                data_valid <= 1'b1;
                state      <= HOLD;
                busy       <= 1'b0;
              end else begin
                win_ct <= win_ct + KW'(1);
              end
            end
          end else if (rise && !got) begin
            got   <= 1'b1;
            sym_q <= symbol_id;
          end
        end
        HOLD: begin
          if (data_ack) begin
            data_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oppm_receiver.sv
// Self-checking bench for oppm_receiver (L=4, N=2, OUTWIDTH=8): directed
// vectors, hand sequences and random pulse trains against a reference model.
module tb_oppm_receiver;

  localparam int L  = 4;
  localparam int N  = 2;
  localparam int OW = 8;
  localparam int P  = int'(oppm_pkg::p_cycles(L, N));
  localparam int K  = OW / N;
  localparam int MAXC = 20000;

  logic          clk;
  logic          rst_n;
  logic          pulse_in;
  logic [OW-1:0] data_out;
  logic          data_valid;
  logic          data_ack;
  logic          frame_err;
  logic          busy;

  oppm_receiver #(.L(L), .N(N), .OUTWIDTH(OW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pulse_in   (pulse_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_reset = -1;
  bit ph [MAXC];

  // Reference model: frame position derived arithmetically from the sync time.
  int            m_mode;   // 0 idle, 1 receiving, 2 holding a word
  int            m_sync;
  bit            m_got;
  int            m_sym;
  logic [OW-1:0] m_word, m_out;
  bit            m_valid, m_err, m_busy;

  typedef struct {
    int            pulses [8];
    int            np;
    bit            exp_valid;
    logic [OW-1:0] exp_word;
    bit            exp_err;
    int            exp_at;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit pv(input int x);
    if (x < 0 || x <= last_reset) return 1'b0;
    return ph[x];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_got = 0; m_sym = 0; m_word = '0; m_out = '0;
    m_valid = 0; m_err = 0; m_busy = 0;
  endtask

  // Raw pulse at call c is seen by the decoder as an edge consumed at call c+3.
  task automatic model_step(input bit rst, input bit ack);
    bit e;
    int d;
    if (rst) begin
      model_reset();
      last_reset = cyc;
      return;
    end
    e = pv(cyc - 3) && !pv(cyc - 4);
    m_err = 0;
    case (m_mode)
      0: if (e) begin
        m_mode = 1; m_sync = cyc; m_got = 0; m_word = '0; m_busy = 1;
      end
      1: begin
        d = cyc - m_sync;
        if (d >= P) begin
          if (e && !m_got) begin
            m_got = 1;
            m_sym = (d % P) / L;
          end
          if (d % P == P - 1) begin
            if (!m_got) begin
              m_err = 1; m_mode = 0; m_busy = 0;
            end else begin
              m_word = (m_word << N) | OW'(m_sym);
              m_got = 0;
              if (d / P - 1 == K - 1) begin
                m_out = m_word; m_valid = 1; m_mode = 2; m_busy = 0;
              end
            end
          end
        end
      end
      default: if (ack) begin
        m_valid = 0; m_mode = 0;
      end
    endcase
  endtask

  task automatic step(input bit p, input bit ack, input bit rst);
    pulse_in = p;
    data_ack = ack;
    rst_n    = !rst;
    ph[cyc]  = p;
    @(posedge clk);
    #1;
    model_step(rst, ack);
    check("data_out", 32'(data_out), 32'(m_out));
    check("data_valid", 32'(data_valid), 32'(m_valid));
    check("frame_err", 32'(frame_err), 32'(m_err));
    check("busy", 32'(busy), 32'(m_busy));
    cyc++;
  endtask

  function automatic bit in_vec(input vec_t v, input int c);
    for (int i = 0; i < v.np; i++)
      if (v.pulses[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Drives one vector frame; pulse at c=t lands at edge time t.
  task automatic run_vec(input vec_t v, input string tag);
    int at = -1;
    bit seen_err = 0;
    for (int c = 0; c < 130; c++) begin
      step(in_vec(v, c), 1'b0, 1'b0);
      if (at < 0 && (data_valid || frame_err)) at = c;
      if (frame_err) seen_err = 1;
    end
    check({tag, "_at"}, 32'(at), 32'(v.exp_at));
    check({tag, "_err"}, 32'(seen_err), 32'(v.exp_err));
    check({tag, "_valid"}, 32'(data_valid), 32'(v.exp_valid));
    if (v.exp_valid) begin
      check({tag, "_word"}, 32'(data_out), 32'(v.exp_word));
      step(1'b0, 1'b1, 1'b0);
      check({tag, "_ack"}, 32'(data_valid), 32'd0);
    end
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    pulse_in = 0; data_ack = 0; rst_n = 0;
    model_reset();
    // Valid rises at t=80 (call 82); a missing window-2 error shows at call 66.
    vecs[0] = '{pulses: '{0, 24, 44, 52, 64, 0, 0, 0}, np: 5, exp_valid: 1, exp_word: 8'hB4, exp_err: 0, exp_at: 82};
    vecs[1] = '{pulses: '{0, 31, 33, 48, 64, 0, 0, 0}, np: 5, exp_valid: 1, exp_word: 8'hC0, exp_err: 0, exp_at: 82};
    vecs[2] = '{pulses: '{0, 24, 44, 64, 0, 0, 0, 0}, np: 4, exp_valid: 0, exp_word: 8'h00, exp_err: 1, exp_at: 66};
    vecs[3] = '{pulses: '{0, 5, 24, 26, 44, 52, 64, 0}, np: 7, exp_valid: 1, exp_word: 8'hB4, exp_err: 0, exp_at: 82};
    vecs[4] = '{pulses: '{0, 23, 32, 63, 79, 0, 0, 0}, np: 5, exp_valid: 1, exp_word: 8'h4F, exp_err: 0, exp_at: 82};

    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("rst_out", 32'(data_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Recovery after an aborted frame.
    run_vec(vecs[0], "recover");

    // Hold a word while a second frame arrives, then ack with an edge on the exit cycle.
    for (int c = 0; c < 301; c++) begin
      bit p;
      p = in_vec(vecs[0], c) || (c >= 100 && in_vec(vecs[4], c - 100)) || c == 297;
      step(p, c == 300, 1'b0);
      if (c == 299) begin
        check("hold_word", 32'(data_out), 32'hB4);
        check("hold_valid", 32'(data_valid), 32'd1);
      end
    end
    check("hold_ack", 32'(data_valid), 32'd0);
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 1'b0);
    check("exit_edge_busy", 32'(busy), 32'd0);

    // Reset mid-frame at edge time t=40.
    for (int c = 0; c < 44; c++) step(c == 0 || c == 24, 1'b0, c == 43);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(data_valid), 32'd0);
    check("midrst_out", 32'(data_out), 32'd0);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0);
    run_vec(vecs[0], "after_rst");

    // Random frames: skipped windows, duplicate and preamble pulses, random acks and resets.
    for (int f = 0; f < 40; f++) begin
      bit fr [140];
      int rst_at;
      foreach (fr[i]) fr[i] = 0;
      fr[0] = 1;
      if ($urandom_range(3, 0) == 0) fr[$urandom_range(14, 2)] = 1;
      for (int k = 0; k < K; k++) begin
        int pos;
        if ($urandom_range(9, 0) == 0) continue;
        pos = P * (k + 1) + L * int'($urandom_range(3, 0)) + int'($urandom_range(L - 1, 0));
        fr[pos] = 1;
        if ($urandom_range(4, 0) == 0 && pos + 2 < 140) fr[pos + 2] = 1;
      end
      rst_at = ($urandom_range(9, 0) == 0) ? int'($urandom_range(100, 10)) : -1;
      for (int c = 0; c < 140; c++)
        step(fr[c], $urandom_range(5, 0) == 0, c == rst_at);
      for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
